// File: rtl/rs_pkg.sv
// Shared RS(15,9) GF(2^4) sizes and scheduler state encoding.
package rs_pkg;

  localparam int unsigned RS_M     = 4;
  localparam int unsigned RS_N     = 15;
  localparam int unsigned RS_K     = 9;
  localparam int unsigned RS_MSG_W = RS_M * RS_K;
  localparam int unsigned RS_CW_W  = RS_M * RS_N;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef logic [RS_MSG_W-1:0] rs_msg_t;
  typedef logic [RS_CW_W-1:0]  rs_cw_t;

endpackage

// File: rtl/rs_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping past NUM_REQ-1 to 0. The caller owns and advances the pointer.
module rs_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_c_o,
  output logic [IDX_W-1:0]   grant_idx_c_o,
  output logic               any_c_o
);

  // ptr_i and off are both below NUM_REQ, so one subtraction wraps the sum.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    grant_idx_c_o = '0;
    any_c_o       = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (req_i[wrap_add(ptr_i, 32'(k))]) begin
        grant_idx_c_o = wrap_add(ptr_i, 32'(k));
        any_c_o       = 1'b1;
      end
    end
    grant_c_o = any_c_o ? (NUM_REQ'(1) << grant_idx_c_o) : '0;
  end

endmodule

// File: rtl/rs_encode_scheduler.sv
// Round-robin scheduler sharing one RS(15,9) encoder among NUM_REQ sources.
// Define RS_SCHED_TIMEOUT_EN to add the encoder busy watchdog (rsp_err_o).
module rs_encode_scheduler
  import rs_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ENC_MIN_LAT    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*RS_MSG_W-1:0]   req_msg_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
  output logic [RS_CW_W-1:0]            rsp_codeword_o,
  output logic                          rsp_err_o,
  output logic [RS_MSG_W-1:0]           enc_message_o,
  output logic                          enc_start_o,
  input  logic                          enc_busy_i,
  input  logic [RS_CW_W-1:0]            enc_codeword_i
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > ENC_MIN_LAT) ? TIMEOUT_CYCLES : ENC_MIN_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(ENC_MIN_LAT - 1);
`ifdef RS_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT_CYCLES);
`endif

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  rs_msg_t            msg_q, msg_d;
  logic [IDX_W-1:0]   id_q, id_d;
  rs_cw_t             cw_q, cw_d;
  logic               valid_q, valid_d;
  logic               start_q, start_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef RS_SCHED_TIMEOUT_EN
  logic               err_q, err_d;
`endif

  logic [NUM_REQ-1:0] arb_grant_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_any_c;
  logic [NUM_REQ-1:0] req_ready_c;
  rs_msg_t            msg_sel_c;

  rs_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i         (req_valid_i),
    .ptr_i         (ptr_q),
    .grant_c_o     (arb_grant_c),
    .grant_idx_c_o (arb_idx_c),
    .any_c_o       (arb_any_c)
  );

  always_comb begin
    msg_sel_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (arb_idx_c == IDX_W'(i)) msg_sel_c = req_msg_i[i*RS_MSG_W +: RS_MSG_W];
    end
  end

  // Next-state logic; ready is gated by reset so no grant is lost to it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    msg_d       = msg_q;
    id_d        = id_q;
    cw_d        = cw_q;
    valid_d     = valid_q;
    start_d     = 1'b0;
    cnt_d       = cnt_q;
`ifdef RS_SCHED_TIMEOUT_EN
    err_d       = err_q;
`endif
    req_ready_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any_c && !reset_i) begin
          req_ready_c = arb_grant_c;
          msg_d       = msg_sel_c;
          id_d        = arb_idx_c;
          start_d     = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= MIN_CNT && !enc_busy_i) begin
          cw_d    = enc_codeword_i;
          valid_d = 1'b1;
          state_d = ST_RESP;
        end
`ifdef RS_SCHED_TIMEOUT_EN
        else if (enc_busy_i && cnt_q >= TMO_CNT) begin
          cw_d    = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          valid_d = 1'b0;
`ifdef RS_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          ptr_d   = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      msg_q   <= '0;
      id_q    <= '0;
      cw_q    <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
`ifdef RS_SCHED_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      msg_q   <= msg_d;
      id_q    <= id_d;
      cw_q    <= cw_d;
      valid_q <= valid_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
`ifdef RS_SCHED_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready_o    = req_ready_c;
  assign rsp_valid_o    = valid_q;
  assign rsp_id_o       = id_q;
  assign rsp_codeword_o = cw_q;
  assign enc_message_o  = msg_q;
  assign enc_start_o    = start_q;
`ifdef RS_SCHED_TIMEOUT_EN
  assign rsp_err_o      = err_q;
`else
  assign rsp_err_o      = 1'b0;
`endif

endmodule
